// File: rtl/mvm_layer_ctrl.sv
// mvm_layer_ctrl: control FSM for one matrix-vector layer stage.
// It loads an M-element vector, issues N rows of M reads each with MAC strobes,
// and presents each finished row on a valid/ready stream.
// Optional feature: define MVM_CTRL_STALL_CNT_EN to add a saturating output-stall counter.
module mvm_layer_ctrl #(
    parameter int M   = 16,
    parameter int N   = 8,
    parameter int XAW = $clog2(M),
    parameter int WAW = $clog2(M*N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           s_valid_x,
    output logic           s_ready_x,
    output logic           x_wr_en,
    output logic [XAW-1:0] x_addr,
    output logic [WAW-1:0] w_addr,
    output logic           acc_clear,
    output logic           acc_en,
    output logic           m_valid_y,
    input  logic           m_ready_y
`ifdef MVM_CTRL_STALL_CNT_EN
    ,
    output logic [31:0]    stall_cnt
`endif
);
    localparam int RW = (N > 1) ? $clog2(N) : 1;
    typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN, OUTPUT} state_t;
    state_t         state;
    logic [XAW-1:0] in_cnt;
    logic [XAW-1:0] col;
    logic [WAW-1:0] w_cnt;
    logic [RW-1:0]  row;
    logic           drain_cnt;
    // input handshake and address muxing; addresses idle at 0 outside their active states
    always_comb begin
        s_ready_x = (state == LOAD) && !reset;
        x_wr_en   = s_ready_x && s_valid_x;
        x_addr    = (state == LOAD) ? in_cnt : (state == COMPUTE) ? col : '0;
        w_addr    = (state == COMPUTE) ? w_cnt : '0;
    end
    // sequencing FSM; accumulator strobes trail the read issue by one stage to match memory latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= LOAD;
            in_cnt    <= '0;
            col       <= '0;
            w_cnt     <= '0;
            row       <= '0;
            drain_cnt <= 1'b0;
            acc_en    <= 1'b0;
            acc_clear <= 1'b0;
            m_valid_y <= 1'b0;
        end else begin
            acc_en    <= (state == COMPUTE);
            acc_clear <= (state == COMPUTE) && (col == '0);
            case (state)
                LOAD: begin
                    if (x_wr_en) begin
                        in_cnt <= in_cnt + XAW'(1);
                        if (in_cnt == XAW'(M-1)) begin
                            in_cnt <= '0;
                            row    <= '0;
                            col    <= '0;
                            w_cnt  <= '0;
                            state  <= COMPUTE;
                        end
                    end
                end
                COMPUTE: begin
                    col   <= col + XAW'(1);
                    w_cnt <= w_cnt + WAW'(1);
                    if (col == XAW'(M-1)) begin
                        col   <= '0;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    drain_cnt <= !drain_cnt;
                    if (drain_cnt) begin
                        state     <= OUTPUT;
                        m_valid_y <= 1'b1;
                    end
                end
                OUTPUT: begin
                    if (m_ready_y) begin
                        m_valid_y <= 1'b0;
                        if (row == RW'(N-1)) begin
                            row   <= '0;
                            w_cnt <= '0;
                            state <= LOAD;
                        end else begin
                            row   <= row + RW'(1);
                            state <= COMPUTE;
                        end
                    end
                end
            endcase
        end
    end
`ifdef MVM_CTRL_STALL_CNT_EN
    // saturating count of cycles a finished row waits on downstream
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt <= '0;
        else if (m_valid_y && !m_ready_y && stall_cnt != '1)
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_mvm_layer_ctrl.sv
// tb_mvm_layer_ctrl: directed bench for mvm_layer_ctrl with M=4, N=3.
module tb_mvm_layer_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s_valid_x = 1'b0;
    logic        m_ready_y = 1'b0;
    logic        s_ready_x;
    logic        x_wr_en;
    logic [1:0]  x_addr;
    logic [3:0]  w_addr;
    logic        acc_clear;
    logic        acc_en;
    logic        m_valid_y;
    logic [10:0] obs;
    int          total = 0;
    int          bad = 0;
`ifdef MVM_CTRL_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    assign obs = {s_ready_x, x_wr_en, x_addr, w_addr, acc_clear, acc_en, m_valid_y};

    mvm_layer_ctrl #(.M(4), .N(3)) dut (
        .clk(clk),
        .reset(reset),
        .s_valid_x(s_valid_x),
        .s_ready_x(s_ready_x),
        .x_wr_en(x_wr_en),
        .x_addr(x_addr),
        .w_addr(w_addr),
        .acc_clear(acc_clear),
        .acc_en(acc_en),
        .m_valid_y(m_valid_y),
        .m_ready_y(m_ready_y)
`ifdef MVM_CTRL_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    // Hand-written schedule for t cycles after COMPUTE entry, no backpressure:
    // each row is 4 issue cycles, 2 drain cycles, 1 output cycle; t=21 is back in LOAD.
    // Fields: {s_ready, wr_en, x_addr, w_addr, clr, en, valid}
    function automatic logic [10:0] sched(input int t);
        int r, o;
        logic [1:0] xa;
        logic [3:0] wa;
        if (t >= 21) return 11'h400;
        r = t / 7;
        o = t % 7;
        xa = (o < 4) ? 2'(o) : 2'd0;
        wa = (o < 4) ? 4'(r * 4 + o) : 4'd0;
        return {1'b0, 1'b0, xa, wa, (o == 1), (o >= 1 && o <= 4), (o == 6)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        total++;
        if (obs !== 11'h000) begin
            bad++;
            $display("FAIL reset_hold got=%h want=%h", obs, 11'h000);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (obs !== 11'h400) begin
            bad++;
            $display("FAIL reset_release got=%h want=%h", obs, 11'h400);
        end
        tick();
    endtask

    task automatic test_basic();
        logic [10:0] e;
        m_ready_y = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s_valid_x = 1'b1;
            #1;
            e = {1'b1, 1'b1, 2'(k), 4'd0, 3'b000};
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL basic_load k=%0d got=%h want=%h", k, obs, e);
            end
            tick();
        end
        for (int t = 0; t <= 21; t++) begin
            s_valid_x = (t < 21);
            #1;
            e = sched(t);
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL basic_run t=%0d got=%h want=%h", t, obs, e);
            end
            tick();
        end
        s_valid_x = 1'b0;
    endtask

    task automatic test_gaps();
        int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
        int cnt = 0;
        logic [10:0] e;
        m_ready_y = 1'b1;
        for (int k = 0; k < 7; k++) begin
            s_valid_x = pat[k][0];
            #1;
            e = {1'b1, pat[k][0], 2'(cnt), 4'd0, 3'b000};
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL gaps_load k=%0d got=%h want=%h", k, obs, e);
            end
            if (pat[k] == 1) cnt++;
            tick();
        end
        s_valid_x = 1'b0;
        for (int t = 0; t <= 21; t++) begin
            #1;
            e = sched(t);
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL gaps_run t=%0d got=%h want=%h", t, obs, e);
            end
            tick();
        end
    endtask

    task automatic test_backpressure(input int want_stall);
        logic [10:0] e;
        m_ready_y = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s_valid_x = 1'b1;
            #1;
            e = {1'b1, 1'b1, 2'(k), 4'd0, 3'b000};
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL bp_load k=%0d got=%h want=%h", k, obs, e);
            end
            tick();
        end
        s_valid_x = 1'b0;
        for (int t = 0; t <= 26; t++) begin
            m_ready_y = !(t >= 13 && t < 18);
            #1;
            e = (t < 13) ? sched(t) : (t < 18) ? 11'h001 : sched(t - 5);
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL bp_run t=%0d got=%h want=%h", t, obs, e);
            end
            tick();
        end
        m_ready_y = 1'b1;
`ifdef MVM_CTRL_STALL_CNT_EN
        total++;
        if (stall_cnt !== 32'(want_stall)) begin
            bad++;
            $display("FAIL stall_cnt got=%0d want=%0d", stall_cnt, want_stall);
        end
`else
        if (want_stall < 0) $display("note: negative stall expectation");
`endif
    endtask

    task automatic test_reset_mid();
        logic [10:0] e;
        m_ready_y = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s_valid_x = 1'b1;
            #1;
            tick();
        end
        s_valid_x = 1'b0;
        for (int t = 0; t <= 9; t++) begin
            #1;
            e = sched(t);
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL mid_pre t=%0d got=%h want=%h", t, obs, e);
            end
            if (t < 9) tick();
        end
        reset = 1'b1;
        #1;
        total++;
        if (obs !== 11'h000) begin
            bad++;
            $display("FAIL mid_async got=%h want=%h", obs, 11'h000);
        end
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (obs !== 11'h400) begin
            bad++;
            $display("FAIL mid_release got=%h want=%h", obs, 11'h400);
        end
        tick();
        total++;
        if (obs !== 11'h400) begin
            bad++;
            $display("FAIL mid_next got=%h want=%h", obs, 11'h400);
        end
        for (int k = 0; k < 4; k++) begin
            s_valid_x = 1'b1;
            #1;
            e = {1'b1, 1'b1, 2'(k), 4'd0, 3'b000};
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL mid_load k=%0d got=%h want=%h", k, obs, e);
            end
            tick();
        end
        s_valid_x = 1'b0;
        for (int t = 0; t <= 21; t++) begin
            #1;
            e = sched(t);
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL mid_run t=%0d got=%h want=%h", t, obs, e);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_backpressure(5);
        test_backpressure(10);
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
